vga_mode_scheduler: RTL

VGA_MODE_SCHEDULER -- requirements
Module: vga_mode_scheduler

---
 rtl/vga_mode_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vga_mode_scheduler.sv
// rtl/vga_mode_scheduler.sv - VGA timing generator with frame-boundary mode switching
// Optional FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module vga_mode_scheduler #(
    parameter int         CNT_WIDTH    = 11,
    parameter logic [1:0] DEFAULT_MODE = 2'd0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Cfg_valid,
    input  logic [1:0]           Cfg_mode,
    output logic                 Cfg_ready,
    output logic                 Hsync,
    output logic                 Vsync,
    output logic [CNT_WIDTH-1:0] Hcount,
    output logic [CNT_WIDTH-1:0] Vcount,
    output logic                 Video_on,
    output logic                 Frame_start,
`ifdef FRAME_CNT_EN
    output logic [15:0]          Frame_count,
`endif
    output logic [1:0]           Mode_active
);

    localparam int H_TOT  [4] = '{800, 1056, 1344, 1688};
    localparam int H_SYNC [4] = '{96, 128, 136, 112};
    localparam int H_BP   [4] = '{48, 88, 160, 248};
    localparam int H_VIS  [4] = '{640, 800, 1024, 1280};
    localparam int V_TOT  [4] = '{525, 628, 806, 1066};
    localparam int V_SYNC [4] = '{2, 4, 6, 3};
    localparam int V_BP   [4] = '{33, 23, 29, 38};
    localparam int V_VIS  [4] = '{480, 600, 768, 1024};

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t               state;
    logic                 started;
    logic [1:0]           pend_mode;
    logic [1:0]           mode_q;
    logic [CNT_WIDTH-1:0] h_cnt;
    logic [CNT_WIDTH-1:0] v_cnt;

    logic                 h_last;
    logic                 v_last;
    logic                 frame_end;
    logic [1:0]           mode_nxt;
    logic [CNT_WIDTH-1:0] h_nxt;
    logic [CNT_WIDTH-1:0] v_nxt;
    int                   h_vis_start;
    int                   v_vis_start;

    assign Hcount      = h_cnt;
    assign Vcount      = v_cnt;
    assign Mode_active = mode_q;

    // Sync/video outputs are decoded from the next counter values so they
    // register on the same edge as the counters they describe.
    always_comb begin
        h_last      = (int'(h_cnt) == H_TOT[mode_q] - 1);
        v_last      = (int'(v_cnt) == V_TOT[mode_q] - 1);
        frame_end   = started && h_last && v_last;
        mode_nxt    = (frame_end && state == PENDING) ? pend_mode : mode_q;
        h_nxt       = CNT_WIDTH'(0);
        v_nxt       = CNT_WIDTH'(0);
        if (started) begin
            if (h_last) begin
                h_nxt = CNT_WIDTH'(0);
                v_nxt = v_last ? CNT_WIDTH'(0) : v_cnt + CNT_WIDTH'(1);
            end else begin
                h_nxt = h_cnt + CNT_WIDTH'(1);
                v_nxt = v_cnt;
            end
        end
        h_vis_start = H_SYNC[mode_nxt] + H_BP[mode_nxt];
        v_vis_start = V_SYNC[mode_nxt] + V_BP[mode_nxt];
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= RUN;
            started     <= 1'b0;
            Cfg_ready   <= 1'b0;
            pend_mode   <= DEFAULT_MODE;
            mode_q      <= DEFAULT_MODE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            Hsync       <= 1'b0;
            Vsync       <= 1'b0;
            Video_on    <= 1'b0;
            Frame_start <= 1'b0;
        end else begin
            started     <= 1'b1;
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            mode_q      <= mode_nxt;
            Hsync       <= (int'(h_nxt) >= H_SYNC[mode_nxt]);
            Vsync       <= (int'(v_nxt) >= V_SYNC[mode_nxt]);
            Video_on    <= (int'(h_nxt) >= h_vis_start)
                        && (int'(h_nxt) <  h_vis_start + H_VIS[mode_nxt])
                        && (int'(v_nxt) >= v_vis_start)
                        && (int'(v_nxt) <  v_vis_start + V_VIS[mode_nxt]);
            Frame_start <= (h_nxt == '0) && (v_nxt == '0);
            case (state)
                RUN: begin
                    if (Cfg_valid && Cfg_ready) begin
                        pend_mode <= Cfg_mode;
                        state     <= PENDING;
                        Cfg_ready <= 1'b0;
                    end else begin
                        Cfg_ready <= 1'b1;
                    end
                end
                PENDING: begin
                    if (frame_end) begin
                        state     <= RUN;
                        Cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= RUN;
                    Cfg_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRAME_CNT_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Frame_count <= 16'd0;
        end else if (frame_end) begin
            Frame_count <= Frame_count + 16'd1;
        end
    end
`endif

endmodule
